// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller bundle between ID-stage signals and pipeline register controls
// master: pipeline side driving hazard sources; slave: the hazard controller.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             redirect;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_hold;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, redirect, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, redirect, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / redirect / memory-wait hazard controller for the IF/ID/EX pipeline
// Optional HAZARD_STATS_EN adds stall_cycles and flush_cycles counters.
module hazard_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int REG_W          = 5
) (
  input  logic                clk,
  input  logic                rst,
`ifdef HAZARD_STATS_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_cycles,
`endif
  hazard_ctrl_if.slave        hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01
  } state_t;

  // Remaining FLUSH-state cycles after the redirect cycle itself, minus one.
  localparam logic [1:0] RELOAD = (BRANCH_PENALTY > 1) ? 2'(BRANCH_PENALTY - 2) : 2'd0;
  localparam bit MULTI_FLUSH = (BRANCH_PENALTY > 1);

  state_t           state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic [REG_W-1:0] rs, rt, lrt;
  logic             load_use;

  assign rs  = hz.id_rs;
  assign rt  = hz.id_rt;
  assign lrt = hz.ex_rt;

  assign load_use = hz.ex_mem_read && (lrt != '0) &&
                    ((lrt == rs) || (hz.id_uses_rt && (lrt == rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hz.pc_write    = 1'b1;
    hz.if_id_write = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.pipe_hold   = 1'b0;

    if (rst) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
    end else if (hz.mem_busy) begin
      // Frozen pipeline keeps its inputs, so redirect/load_use get re-seen later.
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.pipe_hold   = 1'b1;
    end else if (hz.redirect && (state == RUN || state == FLUSH)) begin
      hz.if_id_flush = 1'b1;
      if (MULTI_FLUSH) begin
        state_nxt = FLUSH;
        cnt_nxt   = RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
          end
        end
        FLUSH: begin
          hz.if_id_flush = 1'b1;
          if (cnt == 2'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (!hz.pc_write)   stall_cycles <= stall_cycles + 32'd1;
      if (hz.if_id_flush) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

  // IF/ID only honours flush while writing, so a lone flush would be silently lost.
  a_flush_needs_write: assert property (@(posedge clk) disable iff (rst)
    !(hz.if_id_flush && !hz.if_id_write));

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl with BRANCH_PENALTY=3
module tb_hazard_ctrl;
  localparam int REG_W = 5;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  localparam logic [4:0] IDLE   = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00010;
  localparam logic [4:0] FLSH   = 5'b11100;
  localparam logic [4:0] FROZEN = 5'b00001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.REG_W(REG_W)) hif ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
`endif

  hazard_ctrl #(.BRANCH_PENALTY(3), .REG_W(REG_W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef HAZARD_STATS_EN
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles),
`endif
    .hz           (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic rd, input logic mb);
    hif.ex_mem_read = mr;
    hif.ex_rt       = ert;
    hif.id_rs       = rs;
    hif.id_rt       = rt;
    hif.id_uses_rt  = urt;
    hif.redirect    = rd;
    hif.mem_busy    = mb;
  endtask

  // Samples outputs at the falling edge, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    @(negedge clk);
    obs = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_flush, hif.pipe_hold};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("reset_idle", IDLE);
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("reset_forces_idle", IDLE);
`ifdef HAZARD_STATS_EN
    cmp32("reset_stall_cnt", stall_cycles, 32'd0);
    cmp32("reset_flush_cnt", flush_cycles, 32'd0);
`endif
    rst = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("run_idle", IDLE);

    // Load-use on rs, then load gone.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("load_use_rs", STALL);
    set_in(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("after_stall", IDLE);
    set_in(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    cyc("load_use_rt", STALL);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("r0_no_hazard", IDLE);
    set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("rt_unused_no_hazard", IDLE);

    // mem_busy overrides load_use, which reappears once busy drops.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("busy_over_load_use", FROZEN);
    hif.mem_busy = 1'b0;
    cyc("load_use_after_busy", STALL);
    hif.ex_mem_read = 1'b0;
    cyc("idle_after_busy_stall", IDLE);

    // Isolated redirect: three flush cycles, load_use ignored in cycles 2-3.
    hif.redirect = 1'b1;
    cyc("redirect_flush1", FLSH);
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("redirect_flush2_lu", FLSH);
    cyc("redirect_flush3_lu", FLSH);
    hif.ex_mem_read = 1'b0;
    cyc("redirect_done", IDLE);

    // Freeze for two cycles starting at flush cycle 2.
    hif.redirect = 1'b1;
    cyc("freeze_flush1", FLSH);
    hif.redirect = 1'b0;
    hif.mem_busy = 1'b1;
    cyc("freeze_hold1", FROZEN);
    cyc("freeze_hold2", FROZEN);
    hif.mem_busy = 1'b0;
    cyc("freeze_flush2", FLSH);
    cyc("freeze_flush3", FLSH);
    cyc("freeze_done", IDLE);

    // Redirect inside FLUSH restarts the penalty window.
    hif.redirect = 1'b1;
    cyc("rered_flush1", FLSH);
    hif.redirect = 1'b0;
    cyc("rered_flush2", FLSH);
    hif.redirect = 1'b1;
    cyc("rered_again", FLSH);
    hif.redirect = 1'b0;
    cyc("rered_flush_a", FLSH);
    cyc("rered_flush_b", FLSH);
    cyc("rered_done", IDLE);

    // Reset during flush cycle 2.
    hif.redirect = 1'b1;
    cyc("rstmid_flush1", FLSH);
    hif.redirect = 1'b0;
    rst = 1'b1;
    cyc("rstmid_forced_idle", IDLE);
`ifdef HAZARD_STATS_EN
    cmp32("rstmid_stall_cnt", stall_cycles, 32'd0);
    cmp32("rstmid_flush_cnt", flush_cycles, 32'd0);
`endif
    rst = 1'b0;
    cyc("rstmid_no_residual1", IDLE);
    cyc("rstmid_no_residual2", IDLE);

    // 1 stall + 3-cycle redirect + 3 busy cycles.
    set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("stats_stall", STALL);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("stats_flush1", FLSH);
    hif.redirect = 1'b0;
    cyc("stats_flush2", FLSH);
    cyc("stats_flush3", FLSH);
    hif.mem_busy = 1'b1;
    cyc("stats_busy1", FROZEN);
    cyc("stats_busy2", FROZEN);
    cyc("stats_busy3", FROZEN);
`ifdef HAZARD_STATS_EN
    cmp32("stats_stall_cnt", stall_cycles, 32'd4);
    cmp32("stats_flush_cnt", flush_cycles, 32'd3);
`endif
    hif.mem_busy = 1'b0;
    cyc("stats_idle", IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
